uart_echo_responder: RTL and testbench
======================================

# uart_echo_responder

Hardware console responder on the FPGA side of the serial link: takes bytes from the UART receiver's DataOut/DataOutValid/DataOutReady side and answers through the UART transmitter's DataIn/DataInValid/DataInReady side. It emits a prompt, echoes printable input, handles line-end and backspace, and tracks line length. It serves as the reply-side counterpart to the host-side echo bench, and as a CPU-less link check for bring-up.

## Interface
- MaxLine, 64: maximum characters held per line (1..255).
- SendBootPrompt, 1: emit the prompt once after reset.
- Clock  in  1  system clock; all logic is on the rising edge.
- Reset  in  1  synchronous, active-high.
- RxData  in  8  byte from the UART receiver.
- RxValid  in  1  RxData is valid.
- RxReady  out  1  responder accepts RxData this cycle.
- TxData  out  8  byte to the UART transmitter.
- TxValid  out  1  TxData is valid.
- TxReady  in  1  transmitter accepts TxData this cycle.
- LineLen  out  8  current line length (debug).

## Operation
- Transfer rule: a transfer occurs on an edge where valid and ready are both high.
- States:
  - BOOT: reset state.
  - IDLE: waits for an input byte.
  - SEND: walks a byte sequence.
- Sequences: fixed byte strings; the byte value is given in parentheses.
  - PROMPT: 13, 10, 62, 32 ("\r\n> ").
  - ECHO: the received byte.
  - RUBOUT: 8, 32, 8.
  - BELL: 7.
- BOOT behaviour:
  - With SendBootPrompt=1, the first edge with Reset low enters SEND/PROMPT.
  - With SendBootPrompt=0, it enters IDLE instead.
- IDLE: RxReady=1, TxValid=0. On an Rx transfer the byte is classified as follows:
  - 0x20..0x7E with LineLen<MaxLine: send ECHO, then LineLen+1.
  - 0x20..0x7E with LineLen==MaxLine: send BELL; LineLen is unchanged.
  - 0x0D: send PROMPT; LineLen cleared to 0.
  - 0x08 or 0x7F with LineLen>0: send RUBOUT, then LineLen-1.
  - 0x08 or 0x7F with LineLen==0: send BELL.
  - Any other byte: dropped; stay in IDLE and send nothing.
- SEND:
  - RxReady=0 and TxValid=1.
  - TxData = sequence[index].
  - index advances on each Tx transfer.
  - A Tx transfer on the last byte returns to IDLE.
- LineLen update: takes effect on the edge that accepts the Rx byte, not when the sequence completes.

## Timing
- Reset values: RxReady=0, TxValid=0, TxData=8'h00, LineLen=0, state=BOOT, index=0.
- All outputs are registered, or decoded from registers only. There is no combinational path from RxValid or TxReady to any output.
- Rx accept to first TxValid: 1 cycle. The accept edge loads the sequence, and TxValid is high in the next cycle.
- TxData and TxValid hold stable while TxReady is low. TxValid never drops without a transfer, except on Reset.
- With TxReady held high, an n-byte sequence takes n cycles, followed by 1 IDLE cycle with RxReady=1.
- Sustained throughput is therefore 1 input byte per (n+1) cycles.
- RxValid in BOOT or SEND is ignored; the byte is left pending at the receiver.
- Reset mid-sequence:
  - The sequence is abandoned and TxValid drops in the same edge.
  - LineLen clears.
  - The boot prompt restarts from its first byte.
- LineLen never wraps: it saturates at both MaxLine and 0.

## Structure
- Package uart_echo_pkg holds:
  - the state enum (BOOT, IDLE, SEND);
  - the sequence id enum (PROMPT, ECHO, RUBOUT, BELL);
  - the character constants CR, LF, GT, SP, BS, DEL, BEL.
- Sub-module echo_seq_rom:
  - Purely combinational.
  - Inputs: seq id, index[1:0], echo byte.
  - Outputs: byte and a last flag.
- Top-level contents:
  - the FSM, the index counter, the echo byte register and LineLen;
  - one echo_seq_rom instance.

## Test plan
- Reset 30 cycles, TxReady=1 → TxValid rises 1 cycle after Reset falls; bytes 13,10,62,32 follow on consecutive cycles; then RxReady=1.
- Send 0x7A ('z') → TxData=122 once; LineLen=1.
- Send 0x0D → TxData=13,10,62,32; LineLen=0.
- Type "ab", then 0x7F → TxData=8,32,8 and LineLen=1. Then 0x7F twice: the first gives 8,32,8 with LineLen=0; the second gives 7.
- MaxLine=2; send 'x','y','z' → 120, 121, 7; LineLen remains 2.
- Hold TxReady=0 for 50 cycles during PROMPT → TxData stays 13, TxValid stays 1 and RxReady stays 0. Assert Reset mid-sequence → TxValid=0 the next cycle, and PROMPT restarts after Reset falls.

Source files
------------

// File: rtl/uart_echo_responder_pkg.sv
// Shared types and character constants for the UART echo responder.
// Holds the FSM state enum, the reply-sequence id enum and the ASCII constants.
// Also has a small classifier helper for printable bytes.
package uart_echo_pkg;

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_IDLE,
    ST_SEND
  } state_t;

  typedef enum logic [1:0] {
    SEQ_PROMPT,
    SEQ_ECHO,
    SEQ_RUBOUT,
    SEQ_BELL
  } seq_t;

  localparam logic [7:0] CR  = 8'h0D;
  localparam logic [7:0] LF  = 8'h0A;
  localparam logic [7:0] GT  = 8'h3E;
  localparam logic [7:0] SP  = 8'h20;
  localparam logic [7:0] BS  = 8'h08;
  localparam logic [7:0] DEL = 8'h7F;
  localparam logic [7:0] BEL = 8'h07;

  // Printable ASCII range, space through tilde.
  function automatic logic is_printable(input logic [7:0] b);
    return (b >= SP) && (b <= 8'h7E);
  endfunction

endpackage

// File: rtl/uart_echo_responder_if.sv
// Handshake bundle between the responder and the UART receiver/transmitter.
// Rx side: rx_data/rx_valid in, rx_ready out. Tx side: tx_data/tx_valid out, tx_ready in.
// line_len is a debug view of the current line length.
interface uart_echo_responder_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] line_len;

  // Responder side.
  modport slave (
    input  rx_data, rx_valid, tx_ready,
    output rx_ready, tx_data, tx_valid, line_len
  );

  // UART / environment side.
  modport master (
    output rx_data, rx_valid, tx_ready,
    input  rx_ready, tx_data, tx_valid, line_len
  );
endinterface

// File: rtl/uart_echo_responder_echo_seq_rom.sv
// Reply-sequence ROM: maps (sequence id, index, echo byte) to the byte to send.
// Latency: purely combinational. Backpressure: none, the caller holds the index.
// Ports: i_seq/i_idx/i_echo select the byte; o_byte is the byte, o_last marks the final one.
module echo_seq_rom
  import uart_echo_pkg::*;
(
  input  seq_t       i_seq,
  input  logic [1:0] i_idx,
  input  logic [7:0] i_echo,
  output logic [7:0] o_byte,
  output logic       o_last
);

  always_comb begin
    o_byte = 8'h00;
    o_last = 1'b1;
    case (i_seq)
      SEQ_PROMPT: begin
        o_last = (i_idx == 2'd3);
        case (i_idx)
          2'd0:    o_byte = CR;
          2'd1:    o_byte = LF;
          2'd2:    o_byte = GT;
          default: o_byte = SP;
        endcase
      end
      SEQ_ECHO: begin
        o_byte = i_echo;
      end
      SEQ_RUBOUT: begin
        // Backspace, overwrite with space, backspace again.
        o_last = (i_idx == 2'd2);
        o_byte = (i_idx == 2'd1) ? SP : BS;
      end
      default: begin
        o_byte = BEL;
      end
    endcase
  end

endmodule

// File: rtl/uart_echo_responder.sv
// Console responder: prompt, echo printable bytes, handle CR and backspace, track line length.
// Latency: Rx accept to first TxValid is 1 cycle; n-byte reply takes n cycles plus 1 idle cycle.
// Backpressure: Tx bytes hold while tx_ready is low; rx_ready is low outside IDLE.
// Ports: i_clk, i_rst (sync, active-high), io_bus (slave modport of the echo interface).
module uart_echo_responder
  import uart_echo_pkg::*;
#(
  parameter int MaxLine        = 64,
  parameter bit SendBootPrompt = 1'b1
) (
  input logic                   i_clk,
  input logic                   i_rst,
  uart_echo_responder_if.slave  io_bus
);

  localparam logic [7:0] MAX_LEN = 8'(MaxLine);

  state_t     r_state;
  seq_t       r_seq;
  logic [1:0] r_idx;
  logic [7:0] r_echo;
  logic [7:0] r_line_len;
  logic       r_tx_vld;
  logic       r_rx_rdy;

  logic [7:0] w_rom_byte;
  logic       w_rom_last;

  // Classification of the byte offered on the Rx side while in IDLE.
  logic       w_reply;
  seq_t       w_seq_sel;
  logic [7:0] w_len_next;

  always_comb begin
    w_reply    = 1'b0;
    w_seq_sel  = SEQ_BELL;
    w_len_next = r_line_len;
    if (is_printable(io_bus.rx_data)) begin
      w_reply = 1'b1;
      if (r_line_len < MAX_LEN) begin
        w_seq_sel  = SEQ_ECHO;
        w_len_next = r_line_len + 8'd1;
      end
    end else if (io_bus.rx_data == CR) begin
      w_reply    = 1'b1;
      w_seq_sel  = SEQ_PROMPT;
      w_len_next = 8'd0;
    end else if ((io_bus.rx_data == BS) || (io_bus.rx_data == DEL)) begin
      w_reply = 1'b1;
      if (r_line_len != 8'd0) begin
        w_seq_sel  = SEQ_RUBOUT;
        w_len_next = r_line_len - 8'd1;
      end
    end
  end

  echo_seq_rom u_rom (
    .i_seq  (r_seq),
    .i_idx  (r_idx),
    .i_echo (r_echo),
    .o_byte (w_rom_byte),
    .o_last (w_rom_last)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_BOOT;
      r_seq      <= SEQ_PROMPT;
      r_idx      <= 2'd0;
      r_echo     <= 8'h00;
      r_line_len <= 8'd0;
      r_tx_vld   <= 1'b0;
      r_rx_rdy   <= 1'b0;
    end else begin
      case (r_state)
        ST_BOOT: begin
          r_idx <= 2'd0;
          if (SendBootPrompt) begin
            r_state  <= ST_SEND;
            r_seq    <= SEQ_PROMPT;
            r_tx_vld <= 1'b1;
          end else begin
            r_state  <= ST_IDLE;
            r_rx_rdy <= 1'b1;
          end
        end
        ST_IDLE: begin
          // rx_ready is high throughout IDLE, so rx_valid alone marks a transfer.
          // Unrecognised bytes are consumed without a reply.
          if (io_bus.rx_valid && w_reply) begin
            r_state    <= ST_SEND;
            r_seq      <= w_seq_sel;
            r_idx      <= 2'd0;
            r_echo     <= io_bus.rx_data;
            r_line_len <= w_len_next;
            r_tx_vld   <= 1'b1;
            r_rx_rdy   <= 1'b0;
          end
        end
        ST_SEND: begin
          if (io_bus.tx_ready) begin
            if (w_rom_last) begin
              r_state  <= ST_IDLE;
              r_idx    <= 2'd0;
              r_tx_vld <= 1'b0;
              r_rx_rdy <= 1'b1;
            end else begin
              r_idx <= r_idx + 2'd1;
            end
          end
        end
        default: begin
          r_state  <= ST_BOOT;
          r_tx_vld <= 1'b0;
          r_rx_rdy <= 1'b0;
        end
      endcase
    end
  end

  // TxData is forced to zero whenever nothing is being offered.
  assign io_bus.tx_data  = r_tx_vld ? w_rom_byte : 8'h00;
  assign io_bus.tx_valid = r_tx_vld;
  assign io_bus.rx_ready = r_rx_rdy;
  assign io_bus.line_len = r_line_len;

endmodule

// File: tb/tb_uart_echo_responder.sv
module tb_uart_echo_responder;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  logic [7:0] q1[$];
  logic [7:0] q2[$];

  uart_echo_responder_if bus ();
  uart_echo_responder_if bus2 ();

  uart_echo_responder #(.MaxLine(64), .SendBootPrompt(1'b1)) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_bus (bus)
  );

  uart_echo_responder #(.MaxLine(2), .SendBootPrompt(1'b0)) dut2 (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_bus (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Scoreboards: every Tx transfer must match the next expected byte.
  always @(negedge clk) begin
    if (bus.tx_valid === 1'b1 && bus.tx_ready === 1'b1) begin
      chk("dut1 tx unexpected", (q1.size() != 0), 1);
      if (q1.size() != 0) chk("dut1 tx byte", bus.tx_data, q1.pop_front());
    end
  end

  always @(negedge clk) begin
    if (bus2.tx_valid === 1'b1 && bus2.tx_ready === 1'b1) begin
      chk("dut2 tx unexpected", (q2.size() != 0), 1);
      if (q2.size() != 0) chk("dut2 tx byte", bus2.tx_data, q2.pop_front());
    end
  end

  // Offer one byte when the selected responder is ready; one transfer edge.
  task automatic send_byte(input int which, input logic [7:0] b);
    bit got = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if ((which == 0 ? bus.rx_ready : bus2.rx_ready) === 1'b1) begin
        got = 1;
        break;
      end
    end
    chk("rx_ready wait", got, 1);
    if (which == 0) begin
      bus.rx_data = b; bus.rx_valid = 1'b1;
    end else begin
      bus2.rx_data = b; bus2.rx_valid = 1'b1;
    end
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
    bus2.rx_valid = 1'b0;
  endtask

  task automatic wait_idle(input int which);
    bit done = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (which == 0 && q1.size() == 0 && bus.rx_ready === 1'b1) begin done = 1; break; end
      if (which != 0 && q2.size() == 0 && bus2.rx_ready === 1'b1) begin done = 1; break; end
    end
    chk("idle wait", done, 1);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.rx_data = 8'h00;  bus.rx_valid = 1'b0;  bus.tx_ready = 1'b1;
    bus2.rx_data = 8'h00; bus2.rx_valid = 1'b0; bus2.tx_ready = 1'b1;

    // Reset values.
    repeat (30) @(posedge clk);
    @(negedge clk);
    chk("reset rx_ready", bus.rx_ready, 0);
    chk("reset tx_valid", bus.tx_valid, 0);
    chk("reset tx_data", bus.tx_data, 8'h00);
    chk("reset line_len", bus.line_len, 0);
    chk("reset2 rx_ready", bus2.rx_ready, 0);

    // Boot prompt on dut1; dut2 boots straight to IDLE.
    q1.push_back(8'd13); q1.push_back(8'd10); q1.push_back(8'd62); q1.push_back(8'd32);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("boot tx_valid before edge", bus.tx_valid, 0);
    @(negedge clk);
    chk("boot tx_valid rises", bus.tx_valid, 1);
    chk("boot first byte", bus.tx_data, 8'd13);
    chk("boot2 idle rx_ready", bus2.rx_ready, 1);
    chk("boot2 tx_valid", bus2.tx_valid, 0);
    repeat (3) @(negedge clk);
    chk("boot last byte", bus.tx_data, 8'd32);
    @(negedge clk);
    chk("boot done rx_ready", bus.rx_ready, 1);
    chk("boot done tx_valid", bus.tx_valid, 0);

    // Single echo with exact timing.
    q1.push_back(8'd122);
    send_byte(0, 8'h7A);
    @(negedge clk);
    chk("echo tx_valid", bus.tx_valid, 1);
    chk("echo rx_ready low", bus.rx_ready, 0);
    @(negedge clk);
    chk("echo back to idle", bus.rx_ready, 1);
    chk("echo line_len", bus.line_len, 1);

    // Non-printable control byte is dropped.
    send_byte(0, 8'h01);
    @(negedge clk);
    chk("drop rx_ready", bus.rx_ready, 1);
    chk("drop tx_valid", bus.tx_valid, 0);
    chk("drop line_len", bus.line_len, 1);

    // Carriage return: prompt, length cleared.
    q1.push_back(8'd13); q1.push_back(8'd10); q1.push_back(8'd62); q1.push_back(8'd32);
    send_byte(0, 8'h0D);
    wait_idle(0);
    chk("cr line_len", bus.line_len, 0);

    // "ab" then three deletes.
    q1.push_back(8'd97); send_byte(0, 8'h61); wait_idle(0);
    q1.push_back(8'd98); send_byte(0, 8'h62); wait_idle(0);
    chk("ab line_len", bus.line_len, 2);
    q1.push_back(8'd8); q1.push_back(8'd32); q1.push_back(8'd8);
    send_byte(0, 8'h7F); wait_idle(0);
    chk("del1 line_len", bus.line_len, 1);
    q1.push_back(8'd8); q1.push_back(8'd32); q1.push_back(8'd8);
    send_byte(0, 8'h7F); wait_idle(0);
    chk("del2 line_len", bus.line_len, 0);
    q1.push_back(8'd7);
    send_byte(0, 8'h08); wait_idle(0);
    chk("bs at zero line_len", bus.line_len, 0);

    // Line full on the MaxLine=2 instance.
    q2.push_back(8'd120); send_byte(1, 8'h78); wait_idle(1);
    q2.push_back(8'd121); send_byte(1, 8'h79); wait_idle(1);
    q2.push_back(8'd7);   send_byte(1, 8'h7A); wait_idle(1);
    chk("full line_len", bus2.line_len, 2);

    // Prompt under backpressure, then reset mid-sequence.
    bus.tx_ready = 1'b0;
    send_byte(0, 8'h0D);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk("stall tx_data", bus.tx_data, 8'd13);
      chk("stall tx_valid", bus.tx_valid, 1);
      chk("stall rx_ready", bus.rx_ready, 0);
    end
    rst = 1'b1;
    @(negedge clk);
    chk("midreset tx_valid", bus.tx_valid, 0);
    chk("midreset line_len2", bus2.line_len, 0);
    q1.push_back(8'd13); q1.push_back(8'd10); q1.push_back(8'd62); q1.push_back(8'd32);
    bus.tx_ready = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("restart first byte", bus.tx_data, 8'd13);
    wait_idle(0);
    chk("restart line_len", bus.line_len, 0);

    chk("q1 drained", q1.size(), 0);
    chk("q2 drained", q2.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
